// File: rtl/pwr_mode_sequencer.sv
// pwr_mode_sequencer
//   Top-level power-mode FSM for the solar front end. It selects one of five
//   modes (IDLE, BUCK, BOOST, LED, SHED) from the MPPT threshold flags. Flags
//   are only looked at on ADC sample strobes, and a change must persist for
//   DEBOUNCE strobes before it is accepted. Each mode is held for at least
//   MIN_DWELL cycles. While a converter mode is active, a rate-limited
//   mppt_tick is produced.
//
// Ports
//   clk            system clock, posedge
//   rst            synchronous active-high reset
//   sample_valid   one-cycle strobe; flags are valid on this cycle
//   cap_charged    capacitor fully charged
//   cap_over5      capacitor above 5 V
//   PV_power_high  panel power above threshold
//   pwr_low1       low PV power, capacitor below 7 V
//   pwr_low2       low PV power, capacitor below 13 V
//   state_number   current mode: 0 IDLE, 1 BUCK, 2 BOOST, 3 LED, 4 SHED
//   buck_en / boost_en / led_en   one-hot converter enables
//   mppt_tick      one-cycle duty-update enable
//   state_changed  one-cycle pulse when state_number takes a new value
module pwr_mode_sequencer #(
  parameter int DEBOUNCE   = 4,
  parameter int MIN_DWELL  = 1000,
  parameter int UPDATE_DIV = 50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sample_valid,
  input  logic       cap_charged,
  input  logic       cap_over5,
  input  logic       PV_power_high,
  input  logic       pwr_low1,
  input  logic       pwr_low2,
  output logic [2:0] state_number,
  output logic       buck_en,
  output logic       boost_en,
  output logic       led_en,
  output logic       mppt_tick,
  output logic       state_changed
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_BUCK  = 3'd1;
  localparam logic [2:0] S_BOOST = 3'd2;
  localparam logic [2:0] S_LED   = 3'd3;
  localparam logic [2:0] S_SHED  = 3'd4;

  localparam logic [7:0]  DEB_MAX   = 8'(DEBOUNCE);
  localparam logic [15:0] DWELL_MAX = 16'(MIN_DWELL);
  localparam logic [15:0] DIV_LAST  = 16'(UPDATE_DIV - 1);

  logic [2:0]  state_q, state_d;
  logic [2:0]  pend_q, pend_d;
  logic [7:0]  deb_cnt_q, deb_cnt_d;
  logic [15:0] dwell_q, dwell_d;
  logic [15:0] div_q, div_d;
  logic        buck_en_q, buck_en_d;
  logic        boost_en_q, boost_en_d;
  logic        led_en_q, led_en_d;
  logic        tick_q, tick_d;
  logic        changed_q, changed_d;

  logic [2:0]  cand;
  logic        illegal, dwell_ok, fire, active;

  // Candidate target: first matching rule wins, otherwise stay put.
  always_comb begin
    cand = state_q;
    case (state_q)
      S_IDLE: begin
        if (cap_charged && !pwr_low2)          cand = S_LED;
        else if (PV_power_high && !cap_over5)  cand = S_BUCK;
        else if (PV_power_high && cap_over5)   cand = S_BOOST;
      end
      S_BUCK: begin
        if (!PV_power_high)  cand = S_IDLE;
        else if (cap_over5)  cand = S_BOOST;
      end
      S_BOOST: begin
        if (!PV_power_high)    cand = S_IDLE;
        else if (cap_charged)  cand = S_LED;
      end
      S_LED:   if (pwr_low1)  cand = S_SHED;
      S_SHED:  if (!pwr_low2) cand = S_IDLE;
      default: cand = S_IDLE;
    endcase
  end

  // Encodings 5..7 are unreachable; recover to IDLE immediately, bypassing
  // debounce and dwell.
  assign illegal  = (state_q > S_SHED);
  assign dwell_ok = (dwell_q == DWELL_MAX);
  // Firing looks at the registered count, so no strobe is needed on the
  // firing cycle itself.
  assign fire     = illegal || ((deb_cnt_q == DEB_MAX) && dwell_ok);
  assign active   = (state_q == S_BUCK) || (state_q == S_BOOST) || (state_q == S_LED);

  always_comb begin
    state_d = state_q;
    if (illegal)   state_d = S_IDLE;
    else if (fire) state_d = pend_q;
  end

  // Debounce: only strobe cycles move the count or the pending target.
  always_comb begin
    deb_cnt_d = deb_cnt_q;
    pend_d    = pend_q;
    if (fire) begin
      deb_cnt_d = 8'd0;
    end else if (sample_valid) begin
      if (cand == state_q) begin
        deb_cnt_d = 8'd0;
      end else if (cand == pend_q) begin
        deb_cnt_d = (deb_cnt_q == DEB_MAX) ? deb_cnt_q : deb_cnt_q + 8'd1;
      end else begin
        pend_d    = cand;
        deb_cnt_d = 8'd1;
      end
    end
  end

  always_comb begin
    dwell_d = dwell_q;
    if (fire)           dwell_d = 16'd0;
    else if (!dwell_ok) dwell_d = dwell_q + 16'd1;
  end

  // Tick is registered from the divider reaching its last value, so the
  // first pulse lands UPDATE_DIV cycles after entering a converter mode.
  always_comb begin
    div_d = 16'd0;
    if (active && !fire) div_d = (div_q == DIV_LAST) ? 16'd0 : div_q + 16'd1;
  end

  always_comb begin
    tick_d     = active && !fire && (div_q == DIV_LAST);
    changed_d  = (state_d != state_q);
    buck_en_d  = (state_d == S_BUCK);
    boost_en_d = (state_d == S_BOOST);
    led_en_d   = (state_d == S_LED);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pend_q     <= S_IDLE;
      deb_cnt_q  <= 8'd0;
      dwell_q    <= 16'd0;
      div_q      <= 16'd0;
      buck_en_q  <= 1'b0;
      boost_en_q <= 1'b0;
      led_en_q   <= 1'b0;
      tick_q     <= 1'b0;
      changed_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      deb_cnt_q  <= deb_cnt_d;
      dwell_q    <= dwell_d;
      div_q      <= div_d;
      buck_en_q  <= buck_en_d;
      boost_en_q <= boost_en_d;
      led_en_q   <= led_en_d;
      tick_q     <= tick_d;
      changed_q  <= changed_d;
    end
  end

  assign state_number  = state_q;
  assign buck_en       = buck_en_q;
  assign boost_en      = boost_en_q;
  assign led_en        = led_en_q;
  assign mppt_tick     = tick_q;
  assign state_changed = changed_q;

endmodule

// File: tb/tb_pwr_mode_sequencer.sv
// Directed bench for pwr_mode_sequencer with DEBOUNCE=2, MIN_DWELL=8,
// UPDATE_DIV=4. Each step pushes the expected output vector
// {state, buck, boost, led, tick, changed} and compares it after the edge.
module tb_pwr_mode_sequencer;

  logic       clk;
  logic       rst;
  logic       sample_valid;
  logic       cap_charged, cap_over5, PV_power_high, pwr_low1, pwr_low2;
  logic [2:0] state_number;
  logic       buck_en, boost_en, led_en, mppt_tick, state_changed;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string      tag;
    logic [7:0] val;
  } exp_t;
  exp_t sb[$];

  pwr_mode_sequencer #(.DEBOUNCE(2), .MIN_DWELL(8), .UPDATE_DIV(4)) dut (
    .clk(clk), .rst(rst), .sample_valid(sample_valid),
    .cap_charged(cap_charged), .cap_over5(cap_over5),
    .PV_power_high(PV_power_high), .pwr_low1(pwr_low1), .pwr_low2(pwr_low2),
    .state_number(state_number), .buck_en(buck_en), .boost_en(boost_en),
    .led_en(led_en), .mppt_tick(mppt_tick), .state_changed(state_changed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] obs;
  assign obs = {state_number, buck_en, boost_en, led_en, mppt_tick, state_changed};

  // One clock: queue the expectation, advance, then compare away from the edge.
  task automatic step(input string tag, input logic [2:0] st, input logic tk, input logic chg);
    exp_t e;
    e.tag = tag;
    e.val = {st, st == 3'd1, st == 3'd2, st == 3'd3, tk, chg};
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    checks++;
    assert (obs === e.val) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", e.tag, obs, e.val);
    end
  endtask

  initial begin
    rst = 1'b1; sample_valid = 1'b0;
    cap_charged = 1'b0; cap_over5 = 1'b0; PV_power_high = 1'b0;
    pwr_low1 = 1'b0; pwr_low2 = 1'b0;

    // Reset state.
    step("reset", 3'd0, 1'b0, 1'b0);
    rst = 1'b0;
    for (int j = 0; j < 9; j++) step("idle_wait", 3'd0, 1'b0, 1'b0);

    // IDLE -> BUCK, strobes every third cycle, dwell already met.
    PV_power_high = 1'b1;
    sample_valid = 1'b1; step("buck_s1", 3'd0, 1'b0, 1'b0);
    sample_valid = 1'b0; step("buck_gap", 3'd0, 1'b0, 1'b0);
    step("buck_gap", 3'd0, 1'b0, 1'b0);
    sample_valid = 1'b1; step("buck_s2", 3'd0, 1'b0, 1'b0);
    sample_valid = 1'b0; step("enter_buck", 3'd1, 1'b0, 1'b1);

    // BUCK -> BOOST with strobes every cycle from cycle 2; dwell blocks until 8.
    step("buck_c1", 3'd1, 1'b0, 1'b0);
    cap_over5 = 1'b1; sample_valid = 1'b1;
    for (int j = 2; j <= 8; j++) step("buck_dwell", 3'd1, (j % 4) == 0, 1'b0);
    step("enter_boost", 3'd2, 1'b0, 1'b1);
    sample_valid = 1'b0;

    // BOOST: ticks at 4, 8, 12 after entry.
    for (int j = 1; j <= 12; j++) step("boost_tick", 3'd2, (j % 4) == 0, 1'b0);

    // Debounce glitch: 1, 0, 1, 1 -> single move to LED after the last pair.
    sample_valid = 1'b1;
    cap_charged = 1'b1; step("glitch_a", 3'd2, 1'b0, 1'b0);
    cap_charged = 1'b0; step("glitch_b", 3'd2, 1'b0, 1'b0);
    cap_charged = 1'b1; step("glitch_c", 3'd2, 1'b0, 1'b0);
    step("glitch_d", 3'd2, 1'b1, 1'b0);
    sample_valid = 1'b0;
    step("enter_led", 3'd3, 1'b0, 1'b1);
    cap_charged = 1'b0;

    // LED -> SHED after dwell, then SHED holds with no ticks.
    for (int j = 1; j <= 8; j++) step("led_tick", 3'd3, (j % 4) == 0, 1'b0);
    pwr_low1 = 1'b1; pwr_low2 = 1'b1; sample_valid = 1'b1;
    step("shed_s1", 3'd3, 1'b0, 1'b0);
    step("shed_s2", 3'd3, 1'b0, 1'b0);
    sample_valid = 1'b0;
    step("enter_shed", 3'd4, 1'b0, 1'b1);
    for (int j = 0; j < 20; j++) step("shed_hold", 3'd4, 1'b0, 1'b0);

    // SHED -> IDLE.
    pwr_low1 = 1'b0; pwr_low2 = 1'b0; sample_valid = 1'b1;
    step("idle_s1", 3'd4, 1'b0, 1'b0);
    step("idle_s2", 3'd4, 1'b0, 1'b0);
    sample_valid = 1'b0;
    step("enter_idle", 3'd0, 1'b0, 1'b1);

    // Simultaneous flags in IDLE: LED rule has priority over BOOST.
    cap_charged = 1'b1; cap_over5 = 1'b1; PV_power_high = 1'b1;
    for (int j = 0; j < 8; j++) step("prio_wait", 3'd0, 1'b0, 1'b0);
    sample_valid = 1'b1;
    step("prio_s1", 3'd0, 1'b0, 1'b0);
    step("prio_s2", 3'd0, 1'b0, 1'b0);
    sample_valid = 1'b0;
    step("prio_led", 3'd3, 1'b0, 1'b1);

    // Reset from LED, then travel to BOOST.
    rst = 1'b1; step("rst_led", 3'd0, 1'b0, 1'b0);
    rst = 1'b0; cap_charged = 1'b0;
    for (int j = 0; j < 8; j++) step("rb_wait", 3'd0, 1'b0, 1'b0);
    sample_valid = 1'b1;
    step("rb_s1", 3'd0, 1'b0, 1'b0);
    step("rb_s2", 3'd0, 1'b0, 1'b0);
    sample_valid = 1'b0;
    step("rb_boost", 3'd2, 1'b0, 1'b1);
    for (int j = 1; j <= 8; j++) step("rb_tick", 3'd2, (j % 4) == 0, 1'b0);

    // One strobe toward LED (count=1), then reset overrides it.
    cap_charged = 1'b1; sample_valid = 1'b1;
    step("pend_s1", 3'd2, 1'b0, 1'b0);
    sample_valid = 1'b0; rst = 1'b1;
    step("rst_boost", 3'd0, 1'b0, 1'b0);
    rst = 1'b0;
    for (int j = 0; j < 8; j++) step("post_rst", 3'd0, 1'b0, 1'b0);

    // Count was cleared: one strobe must not be enough.
    sample_valid = 1'b1; step("post_s1", 3'd0, 1'b0, 1'b0);
    sample_valid = 1'b0;
    for (int j = 0; j < 3; j++) step("no_spurious", 3'd0, 1'b0, 1'b0);
    sample_valid = 1'b1; step("post_s2", 3'd0, 1'b0, 1'b0);
    sample_valid = 1'b0;
    step("post_led", 3'd3, 1'b0, 1'b1);
    step("post_led_hold", 3'd3, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
